// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: read ports, write port, probe, clear request and status.
// The master side drives addresses/write/clear; the slave (register file) returns data and status.
interface regfile_param_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 5
);
   logic              clear_req;
   logic [ADDR_W-1:0] rs1_addr;
   logic [ADDR_W-1:0] rs2_addr;
   logic [XLEN-1:0]   rs1_data;
   logic [XLEN-1:0]   rs2_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [XLEN-1:0]   wr_data;
   logic [XLEN-1:0]   probe_data;
   logic              busy;
   logic              wr_drop;

   modport master (
      output clear_req, rs1_addr, rs2_addr, wr_en, wr_addr, wr_data,
      input  rs1_data, rs2_data, probe_data, busy, wr_drop
   );

   modport slave (
      input  clear_req, rs1_addr, rs2_addr, wr_en, wr_addr, wr_data,
      output rs1_data, rs2_data, probe_data, busy, wr_drop
   );
endinterface

// File: rtl/regfile_param.sv
// Parametrised RV32I integer register file with a one-register-per-cycle clear sequencer.
// Define REGFILE_BYPASS_EN to forward an accepted write combinationally to the read/probe ports.
module regfile_param #(
   parameter int XLEN      = 32,
   parameter int NREGS     = 32,
   parameter int ADDR_W    = 5,
   parameter int PROBE_REG = 4,
   parameter int ZERO_REG0 = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   regfile_param_if.slave  bus
);

   localparam logic [0:0]        ST_CLEAR   = 1'b0;
   localparam logic [0:0]        ST_READY   = 1'b1;
   localparam int                IDX_W      = $clog2(NREGS);
   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NREGS - 1);
   localparam logic [ADDR_W-1:0] PROBE_ADDR = ADDR_W'(PROBE_REG);

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              wr_drop_q, wr_drop_d;
   logic [XLEN-1:0]   regs_q [NREGS];

   logic busy;
   logic wr_in_range;
   logic wr_accept;
   logic wr_reject;
   logic clr_en;

   function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
      return (32'(a) < NREGS);
   endfunction

   function automatic logic addr_hardwired(input logic [ADDR_W-1:0] a);
      return (ZERO_REG0 != 0) && (a == '0);
   endfunction

   // Reads are forced to zero while clearing so stale contents never leak out.
   function automatic logic [XLEN-1:0] read_port(input logic [ADDR_W-1:0] a);
      logic [XLEN-1:0] val;
      val = '0;
      if (!busy && addr_valid(a) && !addr_hardwired(a)) begin
`ifdef REGFILE_BYPASS_EN
         if (wr_accept && (a == bus.wr_addr)) begin
            val = bus.wr_data;
         end else begin
            val = regs_q[a[IDX_W-1:0]];
         end
`else
         val = regs_q[a[IDX_W-1:0]];
`endif
      end
      return val;
   endfunction

   assign busy        = (state_q == ST_CLEAR);
   assign wr_in_range = addr_valid(bus.wr_addr);
   assign wr_accept   = (state_q == ST_READY) && !bus.clear_req && bus.wr_en &&
                        wr_in_range && !addr_hardwired(bus.wr_addr);
   assign wr_reject   = bus.wr_en && ((state_q != ST_READY) || bus.clear_req || !wr_in_range);
   assign clr_en      = rst_n && busy;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wr_drop_d = wr_reject;
      if (state_q == ST_CLEAR) begin
         if (bus.clear_req) begin
            idx_d = '0;
         end else if (idx_q == LAST_IDX) begin
            state_d = ST_READY;
            idx_d   = '0;
         end else begin
            idx_d = idx_q + ADDR_W'(1);
         end
      end else if (bus.clear_req) begin
         state_d = ST_CLEAR;
         idx_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_CLEAR;
         idx_q     <= '0;
         wr_drop_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         wr_drop_q <= wr_drop_d;
      end
   end

   // Storage carries no reset; the clear sequencer zeroes it after reset instead.
   always_ff @(posedge clk) begin
      if (clr_en) begin
         regs_q[idx_q[IDX_W-1:0]] <= '0;
      end else if (wr_accept) begin
         regs_q[bus.wr_addr[IDX_W-1:0]] <= bus.wr_data;
      end
   end

   always_comb begin
      bus.rs1_data   = read_port(bus.rs1_addr);
      bus.rs2_data   = read_port(bus.rs2_addr);
      bus.probe_data = read_port(PROBE_ADDR);
   end

   assign bus.busy    = busy;
   assign bus.wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboarded randomized bench for regfile_param: driver pushes model predictions, monitor compares.
module tb_regfile_param;
   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int ADDR_W = 6;
   localparam int PROBE  = 4;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   regfile_param_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

   regfile_param #(
      .XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W), .PROBE_REG(PROBE), .ZERO_REG0(1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   typedef struct {
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] probe;
      logic        busy;
      logic        drop;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model: architectural contents plus "next register still to be cleared".
   logic [31:0] mem [NREGS];
   int          clr_pos = NREGS;
   bit          drop_m  = 1'b0;

   function automatic logic [31:0] model_read(int a, bit acc, int wa, logic [31:0] wd);
      if (clr_pos < NREGS) return 32'h0;
      if (a >= NREGS || a == 0) return 32'h0;
      if (BYP && acc && a == wa) return wd;
      return mem[a];
   endfunction

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
   endtask

   task automatic cyc(bit rst, bit clr, bit we, int wa, logic [31:0] wd, int r1, int r2, bit push);
      exp_t e;
      bit   busy_m;
      bit   acc;
      @(negedge clk);
      #1;
      rst_n         = rst;
      bus.clear_req = clr;
      bus.wr_en     = we;
      bus.wr_addr   = ADDR_W'(wa);
      bus.wr_data   = wd;
      bus.rs1_addr  = ADDR_W'(r1);
      bus.rs2_addr  = ADDR_W'(r2);
      busy_m = (clr_pos < NREGS);
      acc    = !busy_m && !clr && we && (wa < NREGS) && (wa != 0);
      if (push) begin
         e.rs1   = model_read(r1, acc, wa, wd);
         e.rs2   = model_read(r2, acc, wa, wd);
         e.probe = model_read(PROBE, acc, wa, wd);
         e.busy  = busy_m;
         e.drop  = drop_m;
         sb.push_back(e);
      end
      if (!rst) begin
         clr_pos = 0;
         drop_m  = 1'b0;
      end else begin
         drop_m = we && (busy_m || clr || wa >= NREGS);
         if (busy_m) begin
            mem[clr_pos] = 32'h0;
            clr_pos++;
         end
         if (clr) clr_pos = 0;
         if (acc) mem[wa] = wd;
      end
   endtask

   task automatic idle(int r1, int r2);
      cyc(1'b1, 1'b0, 1'b0, 0, 32'h0, r1, r2, 1'b1);
   endtask

   // Monitor: the DUT presents fresh combinational outputs every cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rs1_data", bus.rs1_data, e.rs1);
            check("rs2_data", bus.rs2_data, e.rs2);
            check("probe_data", bus.probe_data, e.probe);
            check("busy", {31'b0, bus.busy}, {31'b0, e.busy});
            check("wr_drop", {31'b0, bus.wr_drop}, {31'b0, e.drop});
         end
      end
   end

   initial begin
      for (int i = 0; i < NREGS; i++) mem[i] = 32'h0;
      bus.clear_req = 1'b0;
      bus.wr_en     = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.rs1_addr  = '0;
      bus.rs2_addr  = '0;

      // Reset for three cycles, then let the clear sequence run.
      cyc(1'b0, 1'b0, 1'b0, 0, 32'h0, 0, 0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 0, 32'h0, 1, 2, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 0, 32'h0, 3, 4, 1'b1);
      for (int i = 0; i < NREGS; i++) idle(i, NREGS - 1 - i);
      idle(5, 0);

      // Directed scenarios.
      cyc(1'b1, 1'b0, 1'b1, 5, 32'hDEADBEEF, 1, 2, 1'b1);
      idle(5, 0);
      cyc(1'b1, 1'b0, 1'b1, 0, 32'h00001234, 3, 5, 1'b1);
      idle(0, 5);
      cyc(1'b1, 1'b0, 1'b1, 4, 32'h00000055, 4, 5, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, 33, 32'h12345678, 4, 33, 1'b1);
      idle(4, 1);
      idle(4, 5);
      cyc(1'b1, 1'b1, 1'b1, 7, 32'h00000077, 7, 5, 1'b1);
      for (int i = 0; i < NREGS; i++) idle(7, 5);
      idle(7, 5);
      cyc(1'b1, 1'b0, 1'b1, 9, 32'hA5A5A5A5, 9, 9, 1'b1);
      idle(9, 4);

      // Reset in the middle of a clear sequence.
      cyc(1'b1, 1'b1, 1'b0, 0, 32'h0, 9, 4, 1'b1);
      for (int i = 0; i < 10; i++) idle(9, 4);
      cyc(1'b0, 1'b0, 1'b1, 3, 32'h3, 9, 4, 1'b1);
      for (int i = 0; i < NREGS + 2; i++) idle(9, i);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 149) != 0), ($urandom_range(0, 59) == 0),
             ($urandom_range(0, 2) != 0), int'($urandom_range(0, 40)), $urandom,
             int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), 1'b1);
      end
      idle(0, 0);
      idle(0, 0);
      @(negedge clk);
      #3;
      n_checks++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
